// File: rtl/seq_mult.sv
// Radix-2 shift-add multiplier for MULT/MULTU: latches operands on start,
// runs WIDTH add/shift steps on magnitudes, then applies the sign in FIX.
//
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   start             request, sampled only while idle
//   is_signed         1 = two's complement operands, 0 = unsigned
//   a, b              multiplicand / multiplier (WIDTH bits)
//   product           {HI, LO}, registered, held until the next done
//   busy              high while an operation is in flight
//   done              one-cycle pulse when product is updated
module seq_mult #(
    parameter int WIDTH = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic               neg_q, neg_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] raw;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mplier_d  = mplier_q;
        mcand_d   = mcand_q;
        neg_d     = neg_q;
        count_d   = count_q;
        product_d = product_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        // Extra bit keeps the carry so it can shift into the acc MSB.
        sum = {1'b0, acc_q}
            + ({1'b0, mcand_q} & {(WIDTH + 1){mplier_q[0]}});
        raw = {acc_q, mplier_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    // -(-2^(W-1)) wraps to 2^(W-1), which is the correct
                    // unsigned magnitude.
                    mcand_d  = (is_signed && a[WIDTH-1]) ? -a : a;
                    mplier_d = (is_signed && b[WIDTH-1]) ? -b : b;
                    neg_d    = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_d    = '0;
                    count_d  = CW'(WIDTH);
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d    = sum[WIDTH:1];
                mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
                count_d  = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                product_d = neg_q ? -raw : raw;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mplier_q  <= '0;
            mcand_q   <= '0;
            neg_q     <= 1'b0;
            count_q   <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mplier_q  <= mplier_d;
            mcand_q   <= mcand_d;
            neg_q     <= neg_d;
            count_q   <= count_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign product = product_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_seq_mult.sv
// Scoreboard bench for seq_mult: directed operand vectors push expected
// products and done edges; a monitor pops and compares on every done.
module tb_seq_mult;

    logic        clock;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] product;
    logic        busy;
    logic        done;

    typedef struct {
        logic [63:0] p;
        int          e;
    } exp_t;

    exp_t sb[$];
    int   errors;
    int   checks;
    int   edges;

    seq_mult #(.WIDTH(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .product   (product),
        .busy      (busy),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) edges <= edges + 1;

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done must match the oldest outstanding request.
    always @(negedge clock) begin
        exp_t e;
        if (!reset && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected 0");
            end else begin
                e = sb.pop_front();
                chk("product", product, e.p);
                chk("done_edge", 64'(edges), 64'(e.e));
                chk("busy_at_done", 64'(busy), 64'd0);
            end
        end
    end

    // Drive one request; done is expected 33 edges after the start edge.
    task automatic issue(input logic s, input logic [31:0] av,
                         input logic [31:0] bv, input logic [63:0] exp);
        exp_t e;
        @(negedge clock);
        is_signed = s;
        a         = av;
        b         = bv;
        start     = 1'b1;
        e.p = exp;
        e.e = edges + 1 + 33;
        sb.push_back(e);
        @(negedge clock);
        start     = 1'b0;
        a         = 32'hDEAD_BEEF;
        b         = 32'h1357_9BDF;
        is_signed = ~s;
        chk("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0",
                     sb.size());
            sb.delete();
        end
    endtask

    initial begin
        exp_t        e;
        logic [63:0] held;
        logic        stable;
        int          n;

        errors    = 0;
        checks    = 0;
        edges     = 0;
        start     = 1'b0;
        is_signed = 1'b0;
        a         = '0;
        b         = '0;
        reset     = 1'b0;
        #2 reset  = 1'b1;
        repeat (2) @(negedge clock);
        chk("rst_product", product, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        reset = 1'b0;

        // Full-range unsigned, then mixed-sign cases.
        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        drain();
        issue(1'b1, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
        drain();
        issue(1'b0, 32'd7, 32'hFFFF_FFFD, 64'h0000_0006_FFFF_FFEB);
        drain();
        issue(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        drain();
        issue(1'b1, 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000);
        drain();
        issue(1'b1, 32'hFFFF_FFFF, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        drain();
        issue(1'b0, 32'h1234_5678, 32'h10, 64'h0000_0001_2345_6780);
        drain();
        issue(1'b1, 32'd0, 32'h8000_0000, 64'd0);
        drain();

        // Reset mid-run aborts at once, then a new request completes.
        issue(1'b0, 32'd9, 32'd9, 64'd81);
        repeat (9) @(negedge clock);
        reset = 1'b1;
        #1;
        sb.delete();
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_product", product, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        issue(1'b0, 32'd6, 32'd7, 64'd42);
        drain();

        // A start while busy is ignored; product then holds steady.
        issue(1'b1, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
        repeat (5) @(negedge clock);
        is_signed = 1'b0;
        a         = 32'd100;
        b         = 32'd100;
        start     = 1'b1;
        @(negedge clock);
        start     = 1'b0;
        drain();
        held   = product;
        stable = 1'b1;
        repeat (40) begin
            @(negedge clock);
            if (product !== held) stable = 1'b0;
        end
        chk("product_hold", 64'(stable), 64'd1);
        chk("held_value", held, 64'hFFFF_FFFF_FFFF_FFEB);

        // Start in the done cycle is accepted.
        issue(1'b0, 32'd11, 32'd13, 64'd143);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!done && n < 100);
        chk("b2b_done_seen", 64'(done), 64'd1);
        is_signed = 1'b0;
        a         = 32'd3;
        b         = 32'd5;
        start     = 1'b1;
        e.p = 64'd15;
        e.e = edges + 1 + 33;
        sb.push_back(e);
        @(negedge clock);
        start = 1'b0;
        chk("b2b_busy", 64'(busy), 64'd1);
        drain();

        repeat (3) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
